// File: rtl/clock_period_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clock_period_monitor_pkg
//   Shared definitions for the clock period monitor: FSM state encodings and
//   the default parameter values used by the top level.
// -----------------------------------------------------------------------------
package clock_period_monitor_pkg;

   // Monitor FSM states. SEEK is the reset state.
   typedef enum logic [1:0] {
      SEEK    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_t;

   // Default widths and expected waveform (divide-by-28, 50% duty).
   localparam int DEF_CNT_W         = 8;
   localparam int DEF_EXPECT_PERIOD = 28;
   localparam int DEF_EXPECT_HIGH   = 14;
   localparam int DEF_LOCK_COUNT    = 2;

endpackage

// File: rtl/edge_sync_detect.sv
// -----------------------------------------------------------------------------
// edge_sync_detect
//   Brings an asynchronous level into the clk_in domain through a two-flop
//   synchronizer (s1, s2), delays it once more (s3) and flags rising edges.
//
// Ports:
//   clk_in  in   sole clock, rising edge
//   rst     in   synchronous active-high reset
//   d       in   asynchronous input level
//   rise    out  high for one cycle after a synchronized 0->1 transition
//   level   out  synchronized level (s2)
// -----------------------------------------------------------------------------
module edge_sync_detect
   import clock_period_monitor_pkg::*;
(
   input  logic clk_in,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic level
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise  = s2 & ~s3;
   assign level = s2;

endmodule

// File: rtl/clock_period_monitor.sv
// -----------------------------------------------------------------------------
// clock_period_monitor
//   Measures the period and high time (in clk_in cycles) of a divided clock
//   and reports lock against an expected waveform.
//
// Parameters:
//   CNT_W          width of counters and of period/high_time
//   EXPECT_PERIOD  expected period in clk_in cycles
//   EXPECT_HIGH    expected high time in clk_in cycles
//   LOCK_COUNT     consecutive matching measurements needed for lock
//
// Ports:
//   clk_in      in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   sig_in      in   monitored divided clock (asynchronous)
//   period      out  last measured period
//   high_time   out  last measured high time
//   meas_valid  out  one-cycle pulse when period/high_time update
//   locked      out  waveform currently matches expectation
//   mismatch    out  one-cycle pulse on a non-matching measurement
//   timeout     out  one-cycle pulse when the period counter saturates
// -----------------------------------------------------------------------------
module clock_period_monitor
   import clock_period_monitor_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int EXPECT_PERIOD = DEF_EXPECT_PERIOD,
   parameter int EXPECT_HIGH   = DEF_EXPECT_HIGH,
   parameter int LOCK_COUNT    = DEF_LOCK_COUNT
)(
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             mismatch,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam int               MATCH_W     = $clog2(LOCK_COUNT + 1);
   localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_COUNT);

   logic rise;
   logic level;

   edge_sync_detect u_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .d      (sig_in),
      .rise   (rise),
      .level  (level)
   );

   mon_state_t         state_reg,      state_next;
   logic [CNT_W-1:0]   per_cnt_reg,    per_cnt_next;
   logic [CNT_W-1:0]   hi_cnt_reg,     hi_cnt_next;
   logic [CNT_W-1:0]   period_reg,     period_next;
   logic [CNT_W-1:0]   high_time_reg,  high_time_next;
   logic [MATCH_W-1:0] match_cnt_reg,  match_cnt_next;
   logic               meas_valid_reg, meas_valid_next;
   logic               locked_reg,     locked_next;
   logic               mismatch_reg,   mismatch_next;
   logic               timeout_reg,    timeout_next;

   // per_cnt starts at 0 on the rise cycle, so the period is one more than
   // the count; clamp so a saturated counter still reports 2^CNT_W-1.
   logic [CNT_W-1:0] meas_period;
   logic             is_match;

   assign meas_period = (per_cnt_reg == CNT_MAX) ? CNT_MAX : per_cnt_reg + CNT_W'(1);
   assign is_match    = (meas_period == CNT_W'(EXPECT_PERIOD)) &&
                        (hi_cnt_reg  == CNT_W'(EXPECT_HIGH));

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_reg      <= SEEK;
         per_cnt_reg    <= '0;
         hi_cnt_reg     <= '0;
         period_reg     <= '0;
         high_time_reg  <= '0;
         match_cnt_reg  <= '0;
         meas_valid_reg <= 1'b0;
         locked_reg     <= 1'b0;
         mismatch_reg   <= 1'b0;
         timeout_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         per_cnt_reg    <= per_cnt_next;
         hi_cnt_reg     <= hi_cnt_next;
         period_reg     <= period_next;
         high_time_reg  <= high_time_next;
         match_cnt_reg  <= match_cnt_next;
         meas_valid_reg <= meas_valid_next;
         locked_reg     <= locked_next;
         mismatch_reg   <= mismatch_next;
         timeout_reg    <= timeout_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      per_cnt_next    = (per_cnt_reg == CNT_MAX) ? CNT_MAX : per_cnt_reg + CNT_W'(1);
      hi_cnt_next     = (level && hi_cnt_reg != CNT_MAX) ? hi_cnt_reg + CNT_W'(1) : hi_cnt_reg;
      period_next     = period_reg;
      high_time_next  = high_time_reg;
      match_cnt_next  = match_cnt_reg;
      meas_valid_next = 1'b0;
      locked_next     = locked_reg;
      mismatch_next   = 1'b0;
      timeout_next    = 1'b0;

      // The rise cycle is itself the first high cycle of the new period.
      if (rise) begin
         per_cnt_next = '0;
         hi_cnt_next  = CNT_W'(1);
      end

      unique case (state_reg)
         SEEK: begin
            // The period in progress is partial, so only start counting.
            if (rise) begin
               state_next = MEASURE;
            end else begin
               per_cnt_next = '0;
               hi_cnt_next  = '0;
            end
         end

         MEASURE, LOCKED: begin
            // A rise takes priority over saturation on the same cycle.
            if (rise) begin
               meas_valid_next = 1'b1;
               period_next     = meas_period;
               high_time_next  = hi_cnt_reg;
               if (!is_match) begin
                  mismatch_next  = 1'b1;
                  match_cnt_next = '0;
                  locked_next    = 1'b0;
                  state_next     = MEASURE;
               end else if (state_reg == MEASURE) begin
                  match_cnt_next = match_cnt_reg + MATCH_W'(1);
                  if (match_cnt_reg + MATCH_W'(1) == LOCK_TARGET) begin
                     locked_next = 1'b1;
                     state_next  = LOCKED;
                  end
               end
            end else if (per_cnt_reg == CNT_MAX) begin
               timeout_next   = 1'b1;
               locked_next    = 1'b0;
               match_cnt_next = '0;
               per_cnt_next   = '0;
               hi_cnt_next    = '0;
               state_next     = SEEK;
            end
         end

         default: state_next = SEEK;
      endcase
   end

   assign period     = period_reg;
   assign high_time  = high_time_reg;
   assign meas_valid = meas_valid_reg;
   assign locked     = locked_reg;
   assign mismatch   = mismatch_reg;
   assign timeout    = timeout_reg;

endmodule

// File: tb/tb_clock_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_period_monitor
//   Directed bench for clock_period_monitor. dut_a expects 28/14, dut_b
//   expects 2/1. Each stimulus period is one vector whose hand-computed
//   expectation (for the measurement emitted at its rise) is queued; monitors
//   pop and compare whenever meas_valid or timeout is seen.
// -----------------------------------------------------------------------------
module tb_clock_period_monitor;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         rst_a, sig_a, mv_a, lk_a, mm_a, to_a;
   logic [W-1:0] per_a, hi_a;
   logic         rst_b, sig_b, mv_b, lk_b, mm_b, to_b;
   logic [W-1:0] per_b, hi_b;

   clock_period_monitor #(
      .CNT_W(W), .EXPECT_PERIOD(28), .EXPECT_HIGH(14), .LOCK_COUNT(2)
   ) dut_a (
      .clk_in(clk), .rst(rst_a), .sig_in(sig_a), .period(per_a), .high_time(hi_a),
      .meas_valid(mv_a), .locked(lk_a), .mismatch(mm_a), .timeout(to_a)
   );

   clock_period_monitor #(
      .CNT_W(W), .EXPECT_PERIOD(2), .EXPECT_HIGH(1), .LOCK_COUNT(2)
   ) dut_b (
      .clk_in(clk), .rst(rst_b), .sig_in(sig_b), .period(per_b), .high_time(hi_b),
      .meas_valid(mv_b), .locked(lk_b), .mismatch(mm_b), .timeout(to_b)
   );

   typedef struct {
      int cyc;
      int ep;
      int eh;
      bit el;
      bit em;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   to_exp_a[$];
   exp_t ea;
   exp_t eb;
   int   checks = 0;
   int   errors = 0;
   int   last_rise_a = 0;

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic flag(string name);
      checks++;
      errors++;
      $display("FAIL %s unexpected event at cycle %0d", name, cyc);
   endtask

   task automatic chk_zero(bit sel_b, string tag);
      if (sel_b) begin
         chk({tag, "_period"},     int'(per_b), 0);
         chk({tag, "_high_time"},  int'(hi_b),  0);
         chk({tag, "_meas_valid"}, int'(mv_b),  0);
         chk({tag, "_locked"},     int'(lk_b),  0);
         chk({tag, "_mismatch"},   int'(mm_b),  0);
         chk({tag, "_timeout"},    int'(to_b),  0);
      end else begin
         chk({tag, "_period"},     int'(per_a), 0);
         chk({tag, "_high_time"},  int'(hi_a),  0);
         chk({tag, "_meas_valid"}, int'(mv_a),  0);
         chk({tag, "_locked"},     int'(lk_a),  0);
         chk({tag, "_mismatch"},   int'(mm_a),  0);
         chk({tag, "_timeout"},    int'(to_a),  0);
      end
   endtask

   // One stimulus period starting at a negedge: high h cycles, low p-h.
   // If meas, the rise of this period must report (ep, eh, el, em) three
   // posedges after sig goes high.
   task automatic vec(bit sel_b, int p, int h, bit meas, int ep, int eh, bit el, bit em);
      exp_t e;
      if (meas) begin
         e.cyc = cyc + 3;
         e.ep  = ep;
         e.eh  = eh;
         e.el  = el;
         e.em  = em;
         if (sel_b) exp_b.push_back(e);
         else       exp_a.push_back(e);
      end
      if (sel_b) begin
         sig_b = 1'b1;
      end else begin
         sig_a = 1'b1;
         last_rise_a = cyc;
      end
      repeat (h) @(negedge clk);
      if (sel_b) sig_b = 1'b0;
      else       sig_a = 1'b0;
      repeat (p - h) @(negedge clk);
   endtask

   // Monitor for dut_a.
   always @(posedge clk) begin
      #1;
      if (mv_a) begin
         if (exp_a.size() == 0) begin
            flag("a_meas_valid");
         end else begin
            ea = exp_a.pop_front();
            chk("a_meas_cycle", cyc,          ea.cyc);
            chk("a_period",     int'(per_a),  ea.ep);
            chk("a_high_time",  int'(hi_a),   ea.eh);
            chk("a_locked",     int'(lk_a),   int'(ea.el));
            chk("a_mismatch",   int'(mm_a),   int'(ea.em));
            $display("a meas cyc=%0d period=%0d high=%0d locked=%0b mismatch=%0b",
                     cyc, per_a, hi_a, lk_a, mm_a);
         end
      end else if (mm_a) begin
         flag("a_mismatch_without_meas");
      end
      if (to_a) begin
         if (to_exp_a.size() == 0) begin
            flag("a_timeout");
         end else begin
            chk("a_timeout_cycle",     cyc,        to_exp_a.pop_front());
            chk("a_locked_at_timeout", int'(lk_a), 0);
            $display("a timeout cyc=%0d", cyc);
         end
      end
   end

   // Monitor for dut_b.
   always @(posedge clk) begin
      #1;
      if (mv_b) begin
         if (exp_b.size() == 0) begin
            flag("b_meas_valid");
         end else begin
            eb = exp_b.pop_front();
            chk("b_meas_cycle", cyc,          eb.cyc);
            chk("b_period",     int'(per_b),  eb.ep);
            chk("b_high_time",  int'(hi_b),   eb.eh);
            chk("b_locked",     int'(lk_b),   int'(eb.el));
            chk("b_mismatch",   int'(mm_b),   int'(eb.em));
            $display("b meas cyc=%0d period=%0d high=%0d locked=%0b mismatch=%0b",
                     cyc, per_b, hi_b, lk_b, mm_b);
         end
      end else if (mm_b) begin
         flag("b_mismatch_without_meas");
      end
      if (to_b) flag("b_timeout");
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      sig_a = 1'b0;
      sig_b = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero(1'b0, "a_reset");
      rst_a = 1'b0;

      // Lock on 28/14: no measurement on first rise, lock on third.
      vec(0, 28, 14, 0,  0,  0, 0, 0);
      vec(0, 28, 14, 1, 28, 14, 0, 0);
      vec(0, 28, 14, 1, 28, 14, 1, 0);
      // Switch to 30/15 while locked.
      vec(0, 30, 15, 1, 28, 14, 1, 0);
      vec(0, 30, 15, 1, 30, 15, 0, 1);
      // Restore 28/14: relock after two matches.
      vec(0, 28, 14, 1, 30, 15, 0, 1);
      vec(0, 28, 14, 1, 28, 14, 0, 0);
      // Wrong duty cycle 28/10.
      vec(0, 28, 10, 1, 28, 14, 1, 0);
      vec(0, 28, 10, 1, 28, 10, 0, 1);
      vec(0, 28, 10, 1, 28, 10, 0, 1);
      vec(0, 28, 14, 1, 28, 10, 0, 1);
      vec(0, 28, 14, 1, 28, 14, 0, 0);
      vec(0, 28, 14, 1, 28, 14, 1, 0);
      // Hold low: timeout 256 cycles after the rise's FSM edge.
      to_exp_a.push_back(last_rise_a + 3 + 256);
      repeat (300) @(negedge clk);
      vec(0, 28, 14, 0,  0,  0, 0, 0);
      vec(0, 28, 14, 1, 28, 14, 0, 0);
      vec(0, 28, 14, 1, 28, 14, 1, 0);

      // Reset while locked.
      chk("a_locked_before_rst", int'(lk_a), 1);
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      chk_zero(1'b0, "a_midrst");
      repeat (10) @(negedge clk);
      rst_a = 1'b0;
      vec(0, 28, 14, 0,  0,  0, 0, 0);
      vec(0, 28, 14, 1, 28, 14, 0, 0);
      vec(0, 28, 14, 1, 28, 14, 1, 0);
      // 256-cycle period: rise coincides with saturation, 255 captured.
      vec(0, 256, 128, 1, 28, 14, 1, 0);
      vec(0, 28, 14, 1, 255, 128, 0, 1);
      vec(0, 28, 14, 1, 28, 14, 0, 0);
      repeat (5) @(negedge clk);
      rst_a = 1'b1;

      // Fastest waveform on dut_b: toggle every cycle.
      chk_zero(1'b1, "b_reset");
      rst_b = 1'b0;
      vec(1, 2, 1, 0, 0, 0, 0, 0);
      vec(1, 2, 1, 1, 2, 1, 0, 0);
      vec(1, 2, 1, 1, 2, 1, 1, 0);
      for (int i = 0; i < 4; i++) vec(1, 2, 1, 1, 2, 1, 1, 0);
      repeat (6) @(negedge clk);
      rst_b = 1'b1;

      chk("a_pending_meas",    exp_a.size(),    0);
      chk("a_pending_timeout", to_exp_a.size(), 0);
      chk("b_pending_meas",    exp_b.size(),    0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
